// File: rtl/param_7sd_pkg.sv
// Shared constants and one-digit BCD arithmetic for the seven-segment counter family.
// Contents:
//   BCD_BASE, BCD_MAX, BCD_W : decimal digit constants
//   AN_OFF                   : inactive level of a common-anode digit select
//   bcd_res_t                : result of a one-digit step (digit + carry/borrow out)
//   bcd_digit_step()         : add or subtract with carry/borrow in, one BCD digit
package param_7sd_pkg;

   localparam int unsigned BCD_BASE = 10;
   localparam int unsigned BCD_MAX  = 9;
   localparam int unsigned BCD_W    = 4;
   localparam logic        AN_OFF   = 1'b1;

   typedef struct packed {
      logic       carry;
      logic [3:0] digit;
   } bcd_res_t;

   // up=1: d + step + cin, carry out when the sum exceeds 9.
   // up=0: d - step - cin, borrow out (reported as carry) when the result goes negative.
   function automatic bcd_res_t bcd_digit_step(input logic [3:0] d,
                                               input logic [3:0] step,
                                               input logic       up,
                                               input logic       cin);
      bcd_res_t   r;
      logic [4:0] t;
      r = '0;
      if (up) begin
         t = 5'(d) + 5'(step) + 5'(cin);
         if (t > 5'(BCD_MAX)) begin
            r.digit = 4'(t - 5'(BCD_BASE));
            r.carry = 1'b1;
         end else begin
            r.digit = 4'(t);
            r.carry = 1'b0;
         end
      end else begin
         // Pre-bias by 10 so the intermediate never underflows.
         t = 5'(d) + 5'(BCD_BASE) - 5'(step) - 5'(cin);
         if (t < 5'(BCD_BASE)) begin
            r.digit = 4'(t);
            r.carry = 1'b1;
         end else begin
            r.digit = 4'(t - 5'(BCD_BASE));
            r.carry = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_step_counter_7sd_if.sv
// Control/data bus of the BCD step counter.
// Signals: tick, dir, load, load_value (requester -> counter);
//          value, wrap (counter -> requester). DIGITS sets the BCD word width.
interface bcd_step_counter_7sd_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  tick;
   logic                  dir;
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic [4*DIGITS-1:0]   value;
   logic                  wrap;

   modport master (output tick, dir, load, load_value, input value, wrap);
   modport slave  (input tick, dir, load, load_value, output value, wrap);
endinterface

// File: rtl/BCDto7SD.sv
// BCD to common-anode seven-segment decoder (segments active low).
// Ports:
//   i_bcd    : 4-bit BCD digit
//   o_seg_c  : {a,b,c,d,e,f,g}, 0 = segment lit; codes above 9 blank the digit
//   o_dp_c   : decimal point, always off
module BCDto7SD (
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg_c,
   output logic       o_dp_c
);

   always_comb begin
      o_seg_c = 7'b1111111;
      o_dp_c  = 1'b1;
      case (i_bcd)
         4'd0:    o_seg_c = 7'b0000001;
         4'd1:    o_seg_c = 7'b1001111;
         4'd2:    o_seg_c = 7'b0010010;
         4'd3:    o_seg_c = 7'b0000110;
         4'd4:    o_seg_c = 7'b1001100;
         4'd5:    o_seg_c = 7'b0100100;
         4'd6:    o_seg_c = 7'b0100000;
         4'd7:    o_seg_c = 7'b0001111;
         4'd8:    o_seg_c = 7'b0000000;
         4'd9:    o_seg_c = 7'b0000100;
         default: o_seg_c = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/bcd_step_counter_7sd.sv
// Multi-digit BCD counter stepping by a fixed STEP modulo 10^DIGITS, with parallel
// load, wrap pulse and a time-multiplexed common-anode seven-segment display.
// Parameters: DIGITS (1..8), STEP (0..9), SCAN_DIV (>=1 cycles per digit).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of bcd_step_counter_7sd_if (tick/dir/load/load_value in,
//                registered value/wrap out)
//   an         : registered active-low one-hot digit select
//   A..G, DP   : segment drives for the selected digit (combinational)
// Build option: BLANK_LEADING_ZERO_EN blanks leading zero digits (digit 0 always lit).
module bcd_step_counter_7sd
   import param_7sd_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned STEP     = 4,
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic               clk,
   input  logic               rst_n,
   bcd_step_counter_7sd_if.slave bus,
   output logic [DIGITS-1:0]  an,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               D,
   output logic               E,
   output logic               F,
   output logic               G,
   output logic               DP
);

   localparam int unsigned VAL_W  = BCD_W * DIGITS;
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   // All digits off except digit 0.
   localparam logic [DIGITS-1:0] AN_RST = {DIGITS{AN_OFF}} ^ DIGITS'(1);

   // Parameter legality
   if (STEP > BCD_MAX) begin : g_bad_step
      $error("bcd_step_counter_7sd: STEP must be 0..9");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_step_counter_7sd: DIGITS must be 1..8");
   end
   if (SCAN_DIV < 1) begin : g_bad_scan
      $error("bcd_step_counter_7sd: SCAN_DIV must be >= 1");
   end

   logic [VAL_W-1:0]  r_value;
   logic              r_wrap;
   logic [SCAN_W-1:0] r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [DIGITS-1:0] r_an;

   logic [VAL_W-1:0]  w_value_nxt;
   logic              w_wrap_nxt;
   logic [SCAN_W-1:0] w_cnt_nxt;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [DIGITS-1:0] w_an_nxt;
   logic [3:0]        w_digit;
   logic [6:0]        w_seg;
   logic              w_dp;

   // Counter next state: load > tick > hold; carry/borrow ripples digit to digit
   always_comb begin : p_count_nxt
      logic     v_carry;
      bcd_res_t v_res;
      w_value_nxt = r_value;
      w_wrap_nxt  = 1'b0;
      v_carry     = 1'b0;
      v_res       = '0;
      if (bus.load) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.load_value[BCD_W*i +: BCD_W] > 4'(BCD_MAX)) begin
               w_value_nxt[BCD_W*i +: BCD_W] = 4'd0;
            end else begin
               w_value_nxt[BCD_W*i +: BCD_W] = bus.load_value[BCD_W*i +: BCD_W];
            end
         end
      end else if (bus.tick) begin
         for (int i = 0; i < int'(DIGITS); i++) begin
            v_res = bcd_digit_step(r_value[BCD_W*i +: BCD_W],
                                   (i == 0) ? 4'(STEP) : 4'd0,
                                   bus.dir, v_carry);
            w_value_nxt[BCD_W*i +: BCD_W] = v_res.digit;
            v_carry = v_res.carry;
         end
         w_wrap_nxt = v_carry;
      end
   end

   // Scan divider and digit index
   always_comb begin : p_scan_nxt
      w_cnt_nxt = r_cnt + SCAN_W'(1);
      w_idx_nxt = r_idx;
      if (r_cnt == SCAN_W'(SCAN_DIV - 1)) begin
         w_cnt_nxt = '0;
         if (r_idx == IDX_W'(DIGITS - 1)) begin
            w_idx_nxt = '0;
         end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
         end
      end
   end

   // Digit select for the next cycle, built from next index and next value so
   // that an and the segment data change together.
   always_comb begin : p_an_nxt
`ifdef BLANK_LEADING_ZERO_EN
      logic v_zero_above;
      v_zero_above = 1'b1;
`endif
      w_an_nxt = {DIGITS{AN_OFF}};
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (IDX_W'(i) == w_idx_nxt) begin
            w_an_nxt[i] = ~AN_OFF;
         end
      end
`ifdef BLANK_LEADING_ZERO_EN
      // Walk down from the top digit; stop blanking at the first nonzero digit.
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         v_zero_above = v_zero_above && (w_value_nxt[BCD_W*i +: BCD_W] == 4'd0);
         if (v_zero_above) begin
            w_an_nxt[i] = AN_OFF;
         end
      end
`endif
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
         r_wrap  <= 1'b0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_an    <= AN_RST;
      end else begin
         r_value <= w_value_nxt;
         r_wrap  <= w_wrap_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_an    <= w_an_nxt;
      end
   end

   // Selected digit feeding the decoder
   always_comb begin : p_digit_mux
      w_digit = 4'd0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (IDX_W'(i) == r_idx) begin
            w_digit = r_value[BCD_W*i +: BCD_W];
         end
      end
   end

   BCDto7SD u_dec (
      .i_bcd   (w_digit),
      .o_seg_c (w_seg),
      .o_dp_c  (w_dp)
   );

   assign bus.value = r_value;
   assign bus.wrap  = r_wrap;
   assign an        = r_an;
   assign {A, B, C, D, E, F, G} = w_seg;
   assign DP        = w_dp;

endmodule

// File: tb/tb_bcd_step_counter_7sd.sv
// Scoreboard bench for bcd_step_counter_7sd: DIGITS=2, STEP=4, SCAN_DIV=4 main
// instance plus a STEP=0 instance.
module tb_bcd_step_counter_7sd;

   localparam int NDIG = 2;
   localparam int STP  = 4;
   localparam int SDIV = 4;

   typedef struct {
      logic [7:0] val;
      logic       wrap;
   } exp_t;

   logic clk;
   logic rst_n;

   bcd_step_counter_7sd_if #(.DIGITS(NDIG)) ifc  ();
   bcd_step_counter_7sd_if #(.DIGITS(NDIG)) ifc0 ();

   logic [NDIG-1:0] an, an0;
   logic A, B, C, D, E, F, G, DP;
   logic A0, B0, C0, D0, E0, F0, G0, DP0;

   bcd_step_counter_7sd #(.DIGITS(NDIG), .STEP(STP), .SCAN_DIV(SDIV)) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .an(an),
      .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .DP(DP)
   );

   bcd_step_counter_7sd #(.DIGITS(NDIG), .STEP(0), .SCAN_DIV(SDIV)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(ifc0.slave), .an(an0),
      .A(A0), .B(B0), .C(C0), .D(D0), .E(E0), .F(F0), .G(G0), .DP(DP0)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   m_val = 0;
   int   m_cnt;
   int   m_idx;
   exp_t sb[$];
   logic [6:0] seg_tab [10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference scan position
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0;
         m_idx <= 0;
      end else if (m_cnt == SDIV - 1) begin
         m_cnt <= 0;
         m_idx <= (m_idx + 1) % NDIG;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int dig_of(input int v, input int idx);
      return (idx == 0) ? (v % 10) : (v / 10);
   endfunction

   function automatic logic [NDIG-1:0] exp_an(input int idx, input int v);
      logic [NDIG-1:0] a;
      a = '1;
      a[idx] = 1'b0;
`ifdef BLANK_LEADING_ZERO_EN
      if (idx == 1 && v / 10 == 0) a[1] = 1'b1;
`endif
      return a;
   endfunction

   // One stimulus cycle on the main instance; expected result goes through the scoreboard.
   task automatic drive(input logic ld, input logic [7:0] lv, input logic tk, input logic up);
      exp_t e;
      int   s, lo, hi;
      @(negedge clk);
      ifc.load = ld; ifc.load_value = lv; ifc.tick = tk; ifc.dir = up;
      e.wrap = 1'b0;
      if (ld) begin
         lo = int'(lv[3:0]); hi = int'(lv[7:4]);
         if (lo > 9) lo = 0;
         if (hi > 9) hi = 0;
         m_val = hi * 10 + lo;
      end else if (tk) begin
         if (up) begin
            s = m_val + STP;
            e.wrap = (s >= 100);
            m_val = s % 100;
         end else begin
            s = m_val - STP;
            e.wrap = (s < 0);
            m_val = (s < 0) ? s + 100 : s;
         end
      end
      e.val = to_bcd(m_val);
      sb.push_back(e);
      @(posedge clk); #1;
      ifc.load = 1'b0; ifc.tick = 1'b0;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("value", 32'(ifc.value), 32'(e.val));
         chk("wrap", 32'(ifc.wrap), 32'(e.wrap));
      end
   endtask

   task automatic check_scan(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         chk("an", 32'(an), 32'(exp_an(m_idx, m_val)));
         chk("seg", 32'({A, B, C, D, E, F, G}), 32'(seg_tab[dig_of(m_val, m_idx)]));
         chk("dp", 32'(DP), 32'd1);
      end
   endtask

   initial begin
      seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
      seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
      seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0000100;
      ifc.load = 0; ifc.tick = 0; ifc.dir = 0; ifc.load_value = '0;
      ifc0.load = 0; ifc0.tick = 0; ifc0.dir = 0; ifc0.load_value = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_value", 32'(ifc.value), 32'h0);
      chk("rst_wrap", 32'(ifc.wrap), 32'h0);
      chk("rst_an", 32'(an), 32'b10);
      chk("rst_seg", 32'({A, B, C, D, E, F, G}), 32'(seg_tab[0]));
      @(negedge clk);
      rst_n = 1'b1;

      // Scan with value 00: digit 0 lit throughout
      check_scan(12);

      drive(1'b1, 8'h57, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);   // 57 -> 53
      drive(1'b1, 8'h03, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);   // 03 -> 99, wrap
      drive(1'b0, 8'h00, 1'b0, 1'b0);   // wrap drops
      drive(1'b1, 8'h98, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 1'b1);   // 98 -> 02, wrap
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      drive(1'b1, 8'h41, 1'b1, 1'b1);   // load wins over tick
      drive(1'b1, 8'hA5, 1'b0, 1'b0);   // illegal tens digit -> 05

      // Scan with value 05 (leading zero blanked when enabled)
      check_scan(10);

      // Back-to-back up then down ticks, crossing zero downward
      repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b1);
      repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'hFF, 1'b0, 1'b0);   // both digits illegal -> 00
      for (int k = 0; k < 24; k++) begin
         drive(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drive(1'b1, 8'h37, 1'b0, 1'b0);
      check_scan(8);

      // STEP = 0 instance: tick leaves the value alone
      @(negedge clk);
      ifc0.load = 1'b1; ifc0.load_value = 8'h98;
      @(posedge clk); #1;
      ifc0.load = 1'b0;
      chk("s0_load", 32'(ifc0.value), 32'h98);
      for (int d = 0; d < 2; d++) begin
         @(negedge clk);
         ifc0.tick = 1'b1; ifc0.dir = 1'(d);
         @(posedge clk); #1;
         ifc0.tick = 1'b0;
         chk("s0_value", 32'(ifc0.value), 32'h98);
         chk("s0_wrap", 32'(ifc0.wrap), 32'h0);
      end

      // Mid-scan asynchronous reset while digit 1 is selected
      for (int k = 0; k < 16 && m_idx != 1; k++) begin
         @(posedge clk); #1;
      end
      chk("idx_reached", 32'(m_idx), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      m_val = 0;
      chk("mrst_an", 32'(an), 32'b10);
      chk("mrst_value", 32'(ifc.value), 32'h0);
      chk("mrst_wrap", 32'(ifc.wrap), 32'h0);
      chk("mrst_value0", 32'(ifc0.value), 32'h0);
      chk("mrst_seg", 32'({A, B, C, D, E, F, G}), 32'(seg_tab[0]));
      @(negedge clk);
      rst_n = 1'b1;
      check_scan(6);
      drive(1'b0, 8'h00, 1'b1, 1'b0);   // 00 -> 96, wrap
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
